// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: variable-length instruction paths, memory-ready
// handshake with timeout, sticky halt, illegal-opcode pulse and retire counter.
module multicycle_control_fsm #(
    parameter int                    OPCODE_W   = 6,
    parameter int                    ALUOP_W    = 2,
    parameter int                    ALUOP_IDLE = 3,
    parameter int                    WAIT_W     = 4,
    parameter int                    MAX_WAIT   = 15,
    parameter int                    CNT_W      = 16,
    parameter logic [OPCODE_W-1:0]   HALT_OP    = {OPCODE_W{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 mem_ready,
    output logic                 regdst,
    output logic                 jump,
    output logic                 branch,
    output logic                 memread,
    output logic                 memtoreg,
    output logic                 memwrite,
    output logic                 alusrc,
    output logic                 regwrite,
    output logic                 pcupdate,
    output logic [ALUOP_W-1:0]   aluop,
    output logic                 halted,
    output logic                 illegal,
    output logic                 mem_err,
    output logic [2:0]           state,
    output logic [CNT_W-1:0]     instr_count
);

    // state  | meaning
    // FETCH  | latch opcode into op_q
    // DECODE | pick path from op_q
    // EXEC   | ALU operation / branch / jump resolve
    // MEM    | data memory access, waits on mem_ready
    // WB     | register file write
    // PCUPD  | PC update, retire instruction
    // HALT   | absorbing until reset
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_PCUPD  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef struct packed {
        logic               regdst;
        logic               jump;
        logic               branch;
        logic               memread;
        logic               memtoreg;
        logic               memwrite;
        logic               alusrc;
        logic               regwrite;
        logic               pcupdate;
        logic               halted;
        logic               illegal;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);

    state_t              st_q, st_n;
    logic [OPCODE_W-1:0] op_q, op_n;
    logic [WAIT_W-1:0]   wait_q, wait_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic                err_q, err_n;
    ctrl_t               ctrl_q;

    function automatic ctrl_t decode(input state_t s, input logic [OPCODE_W-1:0] op);
        ctrl_t              c;
        logic               is_r, is_addi, is_lw, is_sw, is_beq, is_j;
        logic [ALUOP_W-1:0] alu_exec;
        c        = '0;
        c.aluop  = ALUOP_W'(ALUOP_IDLE);
        is_r     = (op == OP_R);
        is_addi  = (op == OP_ADDI);
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        is_beq   = (op == OP_BEQ);
        is_j     = (op == OP_J);
        alu_exec = is_r ? ALUOP_W'(2) : (is_beq ? ALUOP_W'(1) : ALUOP_W'(0));
        case (s)
            S_EXEC: begin
                c.aluop  = alu_exec;
                c.alusrc = is_addi | is_lw | is_sw;
                c.branch = is_beq;
                c.jump   = is_j;
            end
            S_MEM: begin
                c.aluop    = alu_exec;
                c.alusrc   = is_addi | is_lw | is_sw;
                c.memread  = is_lw;
                c.memwrite = is_sw;
            end
            S_WB: begin
                c.aluop    = alu_exec;
                c.alusrc   = is_addi | is_lw | is_sw;
                c.regwrite = 1'b1;
                c.regdst   = is_r;
                c.memtoreg = is_lw;
            end
            S_PCUPD: begin
                c.pcupdate = 1'b1;
                c.branch   = is_beq;
                c.jump     = is_j;
                c.illegal  = ~(is_r | is_addi | is_lw | is_sw | is_beq | is_j);
            end
            S_HALT:  c.halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        st_n   = st_q;
        op_n   = op_q;
        wait_n = wait_q;
        cnt_n  = cnt_q;
        err_n  = err_q;
        case (st_q)
            S_FETCH: begin
                op_n = opcode;
                st_n = S_DECODE;
            end
            S_DECODE: begin
                if (op_q == HALT_OP)
                    st_n = S_HALT;
                else if (op_q == OP_R || op_q == OP_ADDI || op_q == OP_LW ||
                         op_q == OP_SW || op_q == OP_BEQ || op_q == OP_J)
                    st_n = S_EXEC;
                else
                    st_n = S_PCUPD;
            end
            S_EXEC: begin
                if (op_q == OP_LW || op_q == OP_SW)
                    st_n = S_MEM;
                else if (op_q == OP_R || op_q == OP_ADDI)
                    st_n = S_WB;
                else
                    st_n = S_PCUPD;
            end
            S_MEM: begin
                // ready on the last allowed wait cycle still completes normally
                if (mem_ready) begin
                    wait_n = '0;
                    st_n   = (op_q == OP_LW) ? S_WB : S_PCUPD;
                end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
                    wait_n = '0;
                    err_n  = 1'b1;
                    st_n   = S_HALT;
                end else begin
                    wait_n = wait_q + WAIT_W'(1);
                end
            end
            S_WB:    st_n = S_PCUPD;
            S_PCUPD: begin
                st_n = S_FETCH;
                if (cnt_q != '1)
                    cnt_n = cnt_q + CNT_W'(1);
            end
            S_HALT:  st_n = S_HALT;
            default: st_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= S_FETCH;
            op_q   <= '0;
            wait_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            ctrl_q <= decode(S_FETCH, '0);
        end else begin
            st_q   <= st_n;
            op_q   <= op_n;
            wait_q <= wait_n;
            cnt_q  <= cnt_n;
            err_q  <= err_n;
            ctrl_q <= decode(st_n, op_n);
        end
    end

    assign regdst      = ctrl_q.regdst;
    assign jump        = ctrl_q.jump;
    assign branch      = ctrl_q.branch;
    assign memread     = ctrl_q.memread;
    assign memtoreg    = ctrl_q.memtoreg;
    assign memwrite    = ctrl_q.memwrite;
    assign alusrc      = ctrl_q.alusrc;
    assign regwrite    = ctrl_q.regwrite;
    assign pcupdate    = ctrl_q.pcupdate;
    assign aluop       = ctrl_q.aluop;
    assign halted      = ctrl_q.halted;
    assign illegal     = ctrl_q.illegal;
    assign mem_err     = err_q;
    assign state       = st_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm against a path/stage reference model.
module tb_multicycle_control_fsm;

    localparam int MAX_WAIT = 15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = '0;
    logic        mem_ready = 1'b0;
    logic        regdst, jump, branch, memread, memtoreg, memwrite, alusrc;
    logic        regwrite, pcupdate, halted, illegal, mem_err;
    logic [1:0]  aluop;
    logic [2:0]  state;
    logic [15:0] instr_count;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    logic exp_err = 1'b0;
    int path[$];

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .regdst(regdst), .jump(jump), .branch(branch), .memread(memread),
        .memtoreg(memtoreg), .memwrite(memwrite), .alusrc(alusrc),
        .regwrite(regwrite), .pcupdate(pcupdate), .aluop(aluop),
        .halted(halted), .illegal(illegal), .mem_err(mem_err),
        .state(state), .instr_count(instr_count)
    );

    wire [12:0] obs = {regdst, jump, branch, memread, memtoreg, memwrite, alusrc,
                       regwrite, pcupdate, halted, illegal, aluop};

    // Expected controls for one stage: {regdst,jump,branch,memread,memtoreg,
    // memwrite,alusrc,regwrite,pcupdate,halted,illegal,aluop[1:0]}
    function automatic logic [12:0] exp_ctrl(input int stage, input logic [5:0] op);
        logic       r, addi, lw, sw, beq, j, known;
        logic [1:0] alu;
        logic [12:0] v;
        r = (op == OP_R); addi = (op == OP_ADDI); lw = (op == OP_LW);
        sw = (op == OP_SW); beq = (op == OP_BEQ); j = (op == OP_J);
        known = r | addi | lw | sw | beq | j;
        alu = r ? 2'd2 : (beq ? 2'd1 : 2'd0);
        v = {11'b0, 2'd3};
        if (stage == 2) v = {1'b0, j, beq, 3'b000, addi|lw|sw, 4'b0000, alu};
        if (stage == 3) v = {3'b000, lw, 1'b0, sw, addi|lw|sw, 4'b0000, alu};
        if (stage == 4) v = {r, 3'b000, lw, 1'b0, addi|lw|sw, 1'b1, 3'b000, alu};
        if (stage == 5) v = {1'b0, j, beq, 5'b00000, 1'b1, 1'b0, ~known, 2'd3};
        if (stage == 6) v = {9'b0, 1'b1, 1'b0, 2'd3};
        return v;
    endfunction

    task automatic build_path(input logic [5:0] op, input int nwait);
        int mcyc;
        path = {0, 1};
        if (op == OP_HALT) begin
            path.push_back(6);
        end else if (op == OP_R || op == OP_ADDI) begin
            path = {path, 2, 4, 5};
        end else if (op == OP_LW || op == OP_SW) begin
            path.push_back(2);
            mcyc = (nwait <= MAX_WAIT) ? nwait + 1 : MAX_WAIT + 1;
            for (int k = 0; k < mcyc; k++) path.push_back(3);
            if (nwait > MAX_WAIT) path.push_back(6);
            else if (op == OP_LW) path = {path, 4, 5};
            else path.push_back(5);
        end else if (op == OP_BEQ || op == OP_J) begin
            path = {path, 2, 5};
        end else begin
            path.push_back(5);
        end
    endtask

    // Called at a negedge where the DUT should be in FETCH; leaves at the next FETCH
    // (or after a few HALT cycles, or at the aborted stage).
    task automatic run_instr(input string name, input logic [5:0] op,
                             input int nwait, input int abort_at);
        int mseen = 0;
        int extra = 0;
        build_path(op, nwait);
        for (int i = 0; i < path.size() + extra; i++) begin
            int stg;
            stg = (i < path.size()) ? path[i] : 6;
            if (stg == 6 && op != OP_HALT) exp_err = 1'b1;
            if (stg == 6 && i == path.size() - 1) extra = 4;
            checks += 4;
            if (state !== 3'(stg)) begin
                failures++;
                $display("FAIL %s cyc%0d state: got %0d want %0d", name, i, state, stg);
            end
            if (obs !== exp_ctrl(stg, op)) begin
                failures++;
                $display("FAIL %s cyc%0d ctrl: got %b want %b", name, i, obs, exp_ctrl(stg, op));
            end
            if (instr_count !== 16'(exp_cnt)) begin
                failures++;
                $display("FAIL %s cyc%0d instr_count: got %0d want %0d", name, i, instr_count, exp_cnt);
            end
            if (mem_err !== exp_err) begin
                failures++;
                $display("FAIL %s cyc%0d mem_err: got %b want %b", name, i, mem_err, exp_err);
            end
            if (i == abort_at) return;
            if (stg == 5 && exp_cnt < 65535) exp_cnt++;
            opcode = (stg == 0) ? op : 6'($urandom);
            if (stg == 3) begin
                mem_ready = (mseen == nwait);
                mseen++;
            end else begin
                mem_ready = 1'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'($urandom);
        @(negedge clk);
        exp_cnt = 0;
        exp_err = 1'b0;
        checks += 4;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL %s state: got %0d want 0", name, state);
        end
        if (obs !== {11'b0, 2'd3}) begin
            failures++;
            $display("FAIL %s ctrl: got %b want %b", name, obs, {11'b0, 2'd3});
        end
        if (instr_count !== 16'd0) begin
            failures++;
            $display("FAIL %s instr_count: got %0d want 0", name, instr_count);
        end
        if (mem_err !== 1'b0) begin
            failures++;
            $display("FAIL %s mem_err: got %b want 0", name, mem_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_r_type();
        run_instr("r_type", OP_R, 0, -1);
        run_instr("addi", OP_ADDI, 0, -1);
    endtask

    task automatic test_lw_wait();
        run_instr("lw_wait3", OP_LW, 3, -1);
        run_instr("sw_wait0", OP_SW, 0, -1);
    endtask

    task automatic test_sw_timeout();
        run_instr("sw_timeout", OP_SW, 1000, -1);
        do_reset("reset_after_timeout");
    endtask

    task automatic test_beq_j();
        run_instr("beq", OP_BEQ, 0, -1);
        run_instr("j", OP_J, 0, -1);
        checks++;
        if (instr_count !== 16'd2) begin
            failures++;
            $display("FAIL beq_j_count: got %0d want 2", instr_count);
        end
    endtask

    task automatic test_illegal_then_halt();
        run_instr("illegal", 6'b010101, 0, -1);
        run_instr("halt_op", OP_HALT, 0, -1);
        do_reset("reset_after_halt");
    endtask

    task automatic test_ready_at_max();
        run_instr("lw_ready_at_max", OP_LW, MAX_WAIT, -1);
        run_instr("sw_ready_at_max", OP_SW, MAX_WAIT, -1);
    endtask

    task automatic test_reset_mid_mem();
        run_instr("lw_abort", OP_LW, 8, 6);
        do_reset("reset_mid_mem");
        run_instr("r_after_reset", OP_R, 0, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            int sel;
            sel = $urandom_range(0, 6);
            case (sel)
                0: op = OP_R;
                1: op = OP_ADDI;
                2: op = OP_LW;
                3: op = OP_SW;
                4: op = OP_BEQ;
                5: op = OP_J;
                default: begin
                    op = 6'($urandom);
                    while (op == OP_HALT || op == OP_R || op == OP_ADDI || op == OP_LW ||
                           op == OP_SW || op == OP_BEQ || op == OP_J)
                        op = 6'($urandom);
                end
            endcase
            run_instr("random", op, $urandom_range(0, 5), -1);
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_lw_wait();
        test_sw_timeout();
        test_beq_j();
        test_illegal_then_halt();
        test_ready_at_max();
        test_reset_mid_mem();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Parametrised successor to the fixed 5-count multicycle control unit. It is an explicit-state FSM with a variable number of cycles per instruction: each opcode visits only the stages it needs.
- Adds a memory-ready handshake with a wait timeout, a sticky halt state in place of simulation termination, an illegal-opcode flag and a retired-instruction counter.
- Sits between the instruction register (opcode) and the datapath: ALU control, register file, data memory and PC logic.

Parameters:
OPCODE_W, 6, opcode width
ALUOP_W, 2, aluop width
ALUOP_IDLE, 3, aluop value driven outside EXEC/MEM/WB
WAIT_W, 4, width of the memory-wait counter
MAX_WAIT, 15, max cycles MEM may wait for mem_ready before error (1..2^WAIT_W-1)
CNT_W, 16, width of retired-instruction counter
HALT_OP, 6'b111111, opcode that halts the machine

Ports:
clk  in  1  clock, all state changes on posedge
reset  in  1  synchronous, active-high
opcode  in  OPCODE_W  instruction opcode, sampled in FETCH
mem_ready  in  1  data memory done; sampled in MEM
regdst, jump, branch, memread, memtoreg, memwrite, alusrc, regwrite, pcupdate  out  1 each  datapath controls
aluop  out  ALUOP_W  ALU control class
halted  out  1  FSM in HALT
illegal  out  1  one-cycle pulse: undecodable opcode
mem_err  out  1  sticky: MEM wait exceeded MAX_WAIT
state  out  3  current state encoding, for debug
instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, PCUPD=5, HALT=6. Value 7 is unreachable; if entered, go to FETCH.
- Reset (sync): state=FETCH, op_q=0, wait_cnt=0, instr_count=0, mem_err=0. All outputs 0 except aluop=ALUOP_IDLE.
- Reset wins over every other event, including mid-MEM and HALT.
- op_q <= opcode on every cycle spent in FETCH. All later decode uses op_q; opcode may change after FETCH.
- Paths:
  - R (000000), ADDI (001000): FETCH, DECODE, EXEC, WB, PCUPD = 5 cycles.
  - LW (100011): FETCH, DECODE, EXEC, MEM, WB, PCUPD = 6 cycles minimum.
  - SW (101011): FETCH, DECODE, EXEC, MEM, PCUPD = 5 cycles minimum.
  - BEQ (000100), J (000010): FETCH, DECODE, EXEC, PCUPD = 4 cycles.
  - HALT_OP: DECODE to HALT. HALT is absorbing until reset; instr_count is not incremented.
  - Any other opcode: DECODE to PCUPD (skipped instruction). illegal=1 for exactly that PCUPD cycle.
- PCUPD always returns to FETCH.
- Outputs are a Moore decode of (state, op_q); unlisted outputs are 0, and aluop=ALUOP_IDLE outside EXEC/MEM/WB.
  - EXEC: aluop=2 (R), 1 (BEQ), 0 (others). alusrc=1 for ADDI/LW/SW. branch=1 for BEQ. jump=1 for J.
  - MEM: aluop and alusrc as in EXEC. memread=1 (LW), memwrite=1 (SW). Both hold for every wait cycle.
  - WB: regwrite=1. regdst=1 (R). memtoreg=1 (LW). aluop and alusrc as in EXEC.
  - PCUPD: pcupdate=1 for exactly one cycle. branch (BEQ) and jump (J) are re-asserted so PC logic sees them with pcupdate.
  - HALT: halted=1, everything else idle.
- MEM handshake:
  - In MEM, if mem_ready=1, leave next cycle (LW to WB, SW to PCUPD) and clear wait_cnt.
  - Otherwise wait_cnt increments.
  - If wait_cnt==MAX_WAIT while mem_ready=0: mem_err <= 1 and go to HALT.
  - mem_ready=1 in the same cycle as wait_cnt==MAX_WAIT completes normally; ready wins.
  - mem_ready is ignored outside MEM.
- instr_count increments on each PCUPD cycle, including illegal-opcode cycles, and saturates at 2^CNT_W-1.
- Memory strobes never assert outside MEM. regwrite never asserts outside WB.

Test Plan:
- Reset, then opcode=000000 held: state sequence 0,1,2,4,5,0. regwrite=1 and regdst=1 only in WB. aluop=2 in EXEC. pcupdate 1 cycle. instr_count=1.
- LW with mem_ready low 3 cycles then high: memread=1 for 4 MEM cycles. WB has memtoreg=1, regwrite=1. Total 9 cycles FETCH to FETCH. mem_err=0.
- SW with mem_ready never high, MAX_WAIT=15: memwrite held. mem_err=1 and state=6 after MAX_WAIT+1 MEM cycles. halted stays 1; reset returns state=0, mem_err=0.
- BEQ then J: branch=1 in EXEC and PCUPD for BEQ, jump=1 likewise for J. Each takes 4 cycles. instr_count=2.
- opcode=010101: illegal=1 in PCUPD only, no write/memory strobes, then FETCH. Next opcode=111111: halted=1 forever; instr_count unchanged.
- Reset asserted during MEM wait of an LW: next cycle state=0, all strobes 0, aluop=3, instr_count=0. Change opcode after FETCH: decode follows latched op_q.
